// File: rtl/control_multi_if.sv
// control_multi_if: opcode/memory handshake in, datapath controls and status out
interface control_multi_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, PCSource;
    logic [1:0]       ALUSrcA, ALUSrcB, ALUOp;
    logic             illegal, mem_timeout;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       state;
    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, PCSource,
        input  ALUSrcA, ALUSrcB, ALUOp, illegal, mem_timeout, instr_cnt, state
    );
    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, PCSource,
        output ALUSrcA, ALUSrcB, ALUOp, illegal, mem_timeout, instr_cnt, state
    );
endinterface

// File: rtl/control_multi.sv
// control_multi: multi-cycle RV64-subset main control FSM; CONTROL_MULTI_ADDI_EN enables addi (IEXEC)
module control_multi #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input logic            clk,
    input logic            rst_n,
    control_multi_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, IEXEC
    } state_t;
    typedef struct packed {
        logic       pcw, pcwc, iord, irw, mrd, mwr, m2r, rw, pcsrc;
        logic [1:0] srca, srcb, aluop;
    } ctrl_t;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011, OP_ADDI = 7'b0010011;
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.pcw = 1'b1; c.irw = 1'b1; end
            DECODE: begin c.srca = 2'b10; c.srcb = 2'b10; end
            MEMADR: begin c.srca = 2'b01; c.srcb = 2'b10; end
            MEMRD:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            MEMWB:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            MEMWR:  begin c.mwr = 1'b1; c.iord = 1'b1; end
            EXEC:   begin c.srca = 2'b01; c.aluop = 2'b10; end
            IEXEC:  begin c.srca = 2'b01; c.srcb = 2'b10; c.aluop = 2'b11; end
            RWB:    c.rw = 1'b1;
            BRANCH: begin c.srca = 2'b01; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction
    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [6:0]       op_q, op_d;
    logic [WAIT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             bad, stalled, retire;
    always_comb begin
        state_d = state_q;
        bad     = 1'b0;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LD, OP_SD: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
`ifdef CONTROL_MULTI_ADDI_EN
                    OP_ADDI:      state_d = IEXEC;
`endif
                    default: begin state_d = FETCH; bad = 1'b1; end
                endcase
            end
            MEMADR: state_d = (op_q == OP_LD) ? MEMRD : MEMWR;
            MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
            EXEC, IEXEC: state_d = RWB;
            MEMWB, RWB, BRANCH: state_d = FETCH;
            default: state_d = IDLE;
        endcase
        op_d      = (state_q == DECODE) ? bus.opcode : op_q;
        // a stall never coincides with a state change, so clearing on !stalled covers both cases
        stalled   = (state_q inside {FETCH, MEMRD, MEMWR}) && !bus.mem_ready;
        stall_d   = !stalled ? '0 : (stall_q == WAIT_W'(MAX_WAIT)) ? stall_q : stall_q + WAIT_W'(1);
        timeout_d = timeout_q || (stall_d == WAIT_W'(MAX_WAIT));
        retire    = (state_d == FETCH) && (state_q inside {MEMWB, MEMWR, RWB, BRANCH});
        cnt_d     = cnt_q + CNT_W'(retire);
        ctrl_d    = ctrl_of(state_d);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            op_q      <= '0;
            stall_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            op_q      <= op_d;
            stall_q   <= stall_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.PCWrite     = ctrl_q.pcw & bus.mem_ready;
    assign bus.IRWrite     = ctrl_q.irw & bus.mem_ready;
    assign bus.PCWriteCond = ctrl_q.pcwc;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.mrd;
    assign bus.MemWrite    = ctrl_q.mwr;
    assign bus.MemtoReg    = ctrl_q.m2r;
    assign bus.RegWrite    = ctrl_q.rw;
    assign bus.PCSource    = ctrl_q.pcsrc;
    assign bus.ALUSrcA     = ctrl_q.srca;
    assign bus.ALUSrcB     = ctrl_q.srcb;
    assign bus.ALUOp       = ctrl_q.aluop;
    assign bus.illegal     = (state_q == DECODE) && bad;
    assign bus.mem_timeout = timeout_q;
    assign bus.instr_cnt   = cnt_q;
    assign bus.state       = state_q;
endmodule

// File: doc/control_multi.md
# control_multi

Multi-cycle main control unit for the RV64 subset datapath (R-format, ld, sd, beq, optional addi). It replaces per-opcode combinational decode with a Moore state machine that sequences one instruction over 3-5 states, shares one memory port through a ready handshake, and flags illegal opcodes and memory stalls. It sits beside the register file, ALU-control decoder and shared memory. Its opcode input comes from the instruction register, and its outputs drive every datapath mux and write enable.

## Interface
- MAX_WAIT, 15: stall cycles (mem_ready low) in one memory state before mem_timeout sets; 1..2^WAIT_W-1
- WAIT_W, 4: stall counter width
- CNT_W, 16: retired-instruction counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- opcode  in  7  IR[6:0]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, PCSource  out  1 each  datapath controls
- ALUSrcA  out  2  00 PC, 01 A(rs1), 10 OldPC
- ALUSrcB  out  2  00 B(rs2), 01 constant 4, 10 immediate
- ALUOp  out  2  00 add, 01 sub/compare, 10 R-funct, 11 I-funct
- illegal  out  1  one-cycle pulse, unknown opcode in DECODE
- mem_timeout  out  1  sticky stall flag
- instr_cnt  out  CNT_W  retired instructions, wraps
- state  out  4  current state encoding, debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, IEXEC=10.
- Outputs depend only on state. IRWrite and PCWrite also AND in mem_ready. Every output not listed for a state is 0.
- IDLE: all 0. Always goes to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0, IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready=1, else stays.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Latches opcode into op_q.
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC
  - 1100011 -> BRANCH
  - 0010011 -> IEXEC (only with macro)
  - anything else -> FETCH, with illegal=1 this cycle
- MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to MEMRD if op_q is ld, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready.
- MEMWB: RegWrite=1, MemtoReg=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Goes to RWB.
- IEXEC: ALUSrcA=01, ALUSrcB=10, ALUOp=11. Goes to RWB.
- RWB: RegWrite=1, MemtoReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Goes to FETCH.
- instr_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB or BRANCH. It wraps modulo 2^CNT_W. Illegal opcodes do not count.
- Stall counter:
  - Increments each cycle the FSM is in FETCH, MEMRD or MEMWR with mem_ready=0. Saturates at MAX_WAIT.
  - Clears on the handshake and on any state change.
  - When it reaches MAX_WAIT, mem_timeout sets and stays set until reset. The FSM keeps waiting; it never aborts.

## Timing
- Reset: rst_n sampled low at a clk edge gives state=IDLE, op_q=0, stall counter=0, instr_cnt=0, mem_timeout=0. All outputs are therefore 0 during and right after reset.
- rst_n low mid-instruction abandons the instruction; no write enable is asserted after that edge.
- First FETCH is the cycle after rst_n is sampled high.
- Latency with zero-wait memory (mem_ready=1 throughout):
  - ld: 5 cycles
  - sd: 4 cycles
  - R/addi: 4 cycles
  - beq: 3 cycles
- Each wait cycle adds one cycle to the latency.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- mem_timeout rises the cycle after the MAX_WAIT-th consecutive stall cycle.
- If the counter reaches MAX_WAIT in the same cycle the handshake occurs, mem_timeout does not set.

## Configuration
- CONTROL_MULTI_ADDI_EN defined: opcode 0010011 decodes to IEXEC then RWB; addi takes 4 cycles and counts as retired.
- Undefined: 0010011 is illegal (pulse, return to FETCH, not counted). The IEXEC encoding is unreachable.

## Test plan
- Reset then ld, mem_ready=1 throughout -> states 0,1,2,3,4,5,1. RegWrite=MemtoReg=1 only in MEMWB. instr_cnt=1.
- sd with mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles. Back to FETCH after handshake. mem_timeout=0.
- beq then R-format back to back -> PCWriteCond=1 one cycle in BRANCH. ALUOp=10 in EXEC. instr_cnt=2 after 7 cycles.
- opcode 1111111 in DECODE -> illegal=1 one cycle. Next state FETCH. instr_cnt unchanged.
- mem_ready held low 20 cycles in FETCH, MAX_WAIT=15 -> mem_timeout rises after cycle 15 and stays 1 after the later handshake, until rst_n=0.
- rst_n=0 during MEMRD -> next cycle state=IDLE with all outputs 0. Then addi: 4 cycles with the macro defined, illegal pulse without it.
